// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM encoding for the SPI command/register layer.
package spi_reg_pkg;

  localparam int ADDR_W     = 7;
  localparam int CMD_RW_BIT = 7;

  localparam logic [ADDR_W-1:0] ADDR_STAT = 7'h7E;
  localparam logic [ADDR_W-1:0] ADDR_ID   = 7'h7F;

  // Fixed encodings so the debug state output stays stable across revisions.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CMD  = ST_CMD,
    WR   = ST_WR,
    RD   = ST_RD
  } state_e;

endpackage

// File: rtl/spi_edge_det.sv
// Registered edge detector: one stage holds the previous level, rise/fall
// are registered single-cycle pulses.
module spi_edge_det #(
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk_200m,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // Remember last level and flag transitions against it.
  always_ff @(posedge clk_200m or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= RST_LVL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sig_q <= sig;
      rise  <= sig & ~sig_q;
      fall  <= ~sig & sig_q;
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// Byte-level command decoder and control register file behind the SPI slave.
// Protocol per frame: {rw, addr[6:0]} then data bytes, address auto-increments.
//
// Handshake: recv_done / send_done are levels from the slave; only their
// rising edge is an event. send_flag is a one-cycle request that the slave
// must take together with send_data; it is never held or repeated, and
// tx_pending tracks it until the slave reports send_done.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                NREG    = 16,
  parameter logic [7:0]        DEV_ID  = 8'hA5,
  parameter logic [NREG*8-1:0] RST_VAL = '0
) (
  input  logic              clk_200m,
  input  logic              rst_n,
  input  logic              cs,
  input  logic [7:0]        recv_data,
  input  logic              recv_done,
  input  logic              send_done,
  input  logic [7:0]        stat_in,
  output logic [7:0]        send_data,
  output logic              send_flag,
  output logic [NREG*8-1:0] reg_q,
  output logic              wr_stb,
  output logic [6:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              tx_underrun,
  output logic [1:0]        fsm_state
);

  logic              cs_meta;
  logic              cs_sync;
  logic              cs_rise;
  logic              cs_fall;
  logic              rx_ev;
  logic              rx_fall;
  logic              tx_ev;
  logic              tx_fall;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] ptr;
  logic              rsp_req;
  logic              tx_pending;
  logic [7:0]        rd_mux;
  logic              frame_end;
  logic              ptr_in_range;
  logic              unused_edges;
  state_e            state;

  assign unused_edges = rx_fall | tx_fall;
  assign fsm_state    = state;
  assign frame_end    = cs_sync | cs_rise;
  assign ptr_in_range = int'(ptr) < NREG;

  // Two-flop synchroniser for the raw chip select; idles deselected.
  always_ff @(posedge clk_200m or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
    end else begin
      cs_meta <= cs;
      cs_sync <= cs_meta;
    end
  end

  spi_edge_det #(.RST_LVL(1'b1)) u_cs_edge (
    .clk_200m (clk_200m),
    .rst_n    (rst_n),
    .sig      (cs_sync),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  spi_edge_det #(.RST_LVL(1'b0)) u_rx_edge (
    .clk_200m (clk_200m),
    .rst_n    (rst_n),
    .sig      (recv_done),
    .rise     (rx_ev),
    .fall     (rx_fall)
  );

  spi_edge_det #(.RST_LVL(1'b0)) u_tx_edge (
    .clk_200m (clk_200m),
    .rst_n    (rst_n),
    .sig      (send_done),
    .rise     (tx_ev),
    .fall     (tx_fall)
  );

  // Capture the received byte in step with the registered rx event.
  always_ff @(posedge clk_200m or negedge rst_n) begin
    if (!rst_n) rx_byte <= 8'h00;
    else        rx_byte <= recv_data;
  end

  // Response source for the current pointer.
  always_comb begin
    rd_mux = 8'h00;
    if (ptr == ADDR_ID) begin
      rd_mux = DEV_ID;
    end else if (ptr == ADDR_STAT) begin
      rd_mux = stat_in;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ptr == ADDR_W'(i)) rd_mux = reg_q[8*i +: 8];
      end
    end
  end

  // Command FSM, register file writes and response issue.
  always_ff @(posedge clk_200m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      rsp_req     <= 1'b0;
      tx_pending  <= 1'b0;
      tx_underrun <= 1'b0;
      send_data   <= 8'h00;
      send_flag   <= 1'b0;
      reg_q       <= RST_VAL;
      wr_stb      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 8'h00;
    end else begin
      rsp_req   <= 1'b0;
      send_flag <= 1'b0;
      wr_stb    <= 1'b0;
      if (frame_end) begin
        // Deselect wins over any byte or response in flight.
        state      <= IDLE;
        tx_pending <= 1'b0;
      end else begin
        if (tx_ev) tx_pending <= 1'b0;
        if (rsp_req) begin
          send_data  <= rd_mux;
          send_flag  <= 1'b1;
          tx_pending <= 1'b1;
          ptr        <= ptr + 7'd1;
        end
        case (state)
          IDLE: if (cs_fall) state <= CMD;
          CMD: begin
            if (rx_ev) begin
              ptr <= rx_byte[ADDR_W-1:0];
              if (rx_byte[CMD_RW_BIT]) begin
                state   <= RD;
                rsp_req <= 1'b1;
                if (rx_byte[ADDR_W-1:0] == ADDR_STAT) tx_underrun <= 1'b0;
              end else begin
                state <= WR;
              end
            end
          end
          WR: begin
            if (rx_ev) begin
              for (int i = 0; i < NREG; i++) begin
                if (ptr == ADDR_W'(i)) reg_q[8*i +: 8] <= rx_byte;
              end
              if (ptr_in_range) begin
                wr_stb  <= 1'b1;
                wr_addr <= ptr;
                wr_data <= rx_byte;
              end
              ptr <= ptr + 7'd1;
            end
          end
          RD: begin
            if (rx_ev) begin
              rsp_req <= 1'b1;
              if (tx_pending) tx_underrun <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: byte-level SPI slave model on the inputs,
// scoreboards for responses and write strobes, register file model.
module tb_spi_reg_bank;

  localparam int NREG = 16;

  logic              clk_200m = 1'b0;
  logic              rst_n;
  logic              cs;
  logic [7:0]        recv_data;
  logic              recv_done;
  logic              send_done;
  logic [7:0]        stat_in;
  logic [7:0]        send_data;
  logic              send_flag;
  logic [NREG*8-1:0] reg_q;
  logic              wr_stb;
  logic [6:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              tx_underrun;
  logic [1:0]        fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  bit auto_tx = 1'b1;

  logic [7:0]        exp_q[$];
  logic [14:0]       wr_q[$];
  logic [NREG*8-1:0] model_q;

  spi_reg_bank #(.NREG(NREG), .DEV_ID(8'hA5), .RST_VAL('0)) dut (
    .clk_200m    (clk_200m),
    .rst_n       (rst_n),
    .cs          (cs),
    .recv_data   (recv_data),
    .recv_done   (recv_done),
    .send_done   (send_done),
    .stat_in     (stat_in),
    .send_data   (send_data),
    .send_flag   (send_flag),
    .reg_q       (reg_q),
    .wr_stb      (wr_stb),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .tx_underrun (tx_underrun),
    .fsm_state   (fsm_state)
  );

  // Clock
  always #5 clk_200m = ~clk_200m;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Response and write-strobe scoreboard.
  always @(posedge clk_200m) begin
    #1;
    if (send_flag) begin
      if (exp_q.size() == 0) check_val("rsp_unexpected", exp_q.size(), 1);
      else check_val("rsp_data", send_data, exp_q.pop_front());
    end
    if (wr_stb) begin
      if (wr_q.size() == 0) check_val("wr_unexpected", wr_q.size(), 1);
      else check_val("wr_addr_data", {wr_addr, wr_data}, wr_q.pop_front());
    end
  end

  // Slave transmit model: reports completion a few cycles after each request.
  initial begin
    send_done = 1'b0;
    forever begin
      @(posedge clk_200m);
      #1;
      if (send_flag && auto_tx) begin
        repeat (3) @(negedge clk_200m);
        send_done = 1'b1;
        repeat (2) @(negedge clk_200m);
        send_done = 1'b0;
      end
    end
  end

  task automatic exp_write(input logic [6:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
    model_q[8*int'(a) +: 8] = d;
  endtask

  task automatic cs_low();
    @(negedge clk_200m);
    cs = 1'b0;
    repeat (6) @(negedge clk_200m);
  endtask

  task automatic cs_high();
    @(negedge clk_200m);
    cs = 1'b1;
    repeat (6) @(negedge clk_200m);
  endtask

  // One received byte; when a response is due, check its 3-cycle latency.
  task automatic drive_byte(input logic [7:0] b, input bit rsp);
    @(negedge clk_200m);
    recv_data = b;
    recv_done = 1'b1;
    if (rsp) begin
      repeat (2) @(posedge clk_200m);
      #1 check_val("rsp_lat_early", send_flag, 1'b0);
      @(posedge clk_200m);
      #1 check_val("rsp_lat_3", send_flag, 1'b1);
    end else begin
      repeat (3) @(posedge clk_200m);
    end
    @(negedge clk_200m);
    recv_done = 1'b0;
    repeat (8) @(negedge clk_200m);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_send_data"}, send_data, 8'h00);
    check_val({tag, "_send_flag"}, send_flag, 1'b0);
    check_val({tag, "_reg_q"}, reg_q, '0);
    check_val({tag, "_wr_stb"}, wr_stb, 1'b0);
    check_val({tag, "_wr_addr"}, wr_addr, 7'h00);
    check_val({tag, "_wr_data"}, wr_data, 8'h00);
    check_val({tag, "_underrun"}, tx_underrun, 1'b0);
    check_val({tag, "_state"}, fsm_state, 2'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cs        = 1'b1;
    recv_data = 8'h00;
    recv_done = 1'b0;
    stat_in   = 8'h00;
    model_q   = '0;
    repeat (4) @(negedge clk_200m);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk_200m);

    // Write burst starting at register 2.
    cs_low();
    exp_write(7'd2, 8'h11);
    exp_write(7'd3, 8'h22);
    exp_write(7'd4, 8'h33);
    drive_byte(8'h02, 1'b0);
    drive_byte(8'h11, 1'b0);
    drive_byte(8'h22, 1'b0);
    drive_byte(8'h33, 1'b0);
    cs_high();
    check_val("wr_burst_reg2", reg_q[23:16], 8'h11);
    check_val("wr_burst_reg4", reg_q[39:32], 8'h33);
    check_val("wr_burst_regs", reg_q, model_q);
    check_val("wr_burst_idle", fsm_state, 2'd0);

    // Read burst back.
    cs_low();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    drive_byte(8'h82, 1'b1);
    drive_byte(8'h00, 1'b1);
    drive_byte(8'h00, 1'b1);
    cs_high();
    check_val("rd_burst_no_underrun", tx_underrun, 1'b0);

    // Device ID, then pointer wraps to register 0.
    cs_low();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    drive_byte(8'hFF, 1'b1);
    drive_byte(8'h00, 1'b1);
    cs_high();

    // Out-of-range write is ignored and reads back as zero.
    cs_low();
    drive_byte(8'h20, 1'b0);
    drive_byte(8'h5A, 1'b0);
    cs_high();
    check_val("oor_regs", reg_q, model_q);
    cs_low();
    exp_q.push_back(8'h00);
    drive_byte(8'hA0, 1'b1);
    cs_high();

    // Abort mid data byte after a write command to register 5.
    cs_low();
    drive_byte(8'h05, 1'b0);
    @(negedge clk_200m);
    recv_data = 8'h77;
    cs_high();
    check_val("abort_reg5", reg_q[47:40], 8'h00);
    check_val("abort_idle", fsm_state, 2'd0);
    cs_low();
    exp_q.push_back(8'h00);
    drive_byte(8'h85, 1'b1);
    check_val("abort_next_cmd_rd", fsm_state, 2'd3);
    cs_high();

    // Underrun: responses not drained by the slave.
    auto_tx = 1'b0;
    cs_low();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    drive_byte(8'h80, 1'b1);
    check_val("underrun_first_ok", tx_underrun, 1'b0);
    drive_byte(8'h00, 1'b1);
    check_val("underrun_set", tx_underrun, 1'b1);
    cs_high();
    check_val("underrun_sticky", tx_underrun, 1'b1);
    auto_tx = 1'b1;
    stat_in = 8'h3C;
    cs_low();
    exp_q.push_back(8'h3C);
    drive_byte(8'hFE, 1'b1);
    check_val("underrun_cleared", tx_underrun, 1'b0);
    cs_high();

    // Reset in the middle of a write frame.
    cs_low();
    exp_write(7'd8, 8'hC3);
    drive_byte(8'h08, 1'b0);
    drive_byte(8'hC3, 1'b0);
    check_val("midrst_reg8", reg_q[71:64], 8'hC3);
    check_val("midrst_in_wr", fsm_state, 2'd2);
    @(negedge clk_200m);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_200m);
    model_q = '0;
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    cs_high();
    check_val("midrst_regs_after", reg_q, model_q);

    repeat (10) @(negedge clk_200m);
    check_val("rsp_queue_drained", exp_q.size(), 0);
    check_val("wr_queue_drained", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
